// File: rtl/open_list_search_par.sv
// A* open-list store: DEPTH (x,y) entries with valid bits, scanned LANES entries per cycle for a key.
// Optional f-cost storage and result port when OPEN_SEARCH_FCOST_EN is defined.
module open_list_search_par #(
    parameter int COORD_W = 8,
    parameter int DEPTH   = 400,
    parameter int LANES   = 4
`ifdef OPEN_SEARCH_FCOST_EN
    ,
    parameter int FCOST_W = 16
`endif
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic [COORD_W-1:0]         key_x,
    input  logic [COORD_W-1:0]         key_y,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [$clog2(DEPTH)-1:0]   found_idx,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [COORD_W-1:0]         wr_x,
    input  logic [COORD_W-1:0]         wr_y,
    input  logic                       wr_valid,
    input  logic                       clear_all,
`ifdef OPEN_SEARCH_FCOST_EN
    input  logic [FCOST_W-1:0]         wr_fcost,
    output logic [FCOST_W-1:0]         found_fcost,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       o_dbg_state
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int GROUPS = DEPTH / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IDX_W:0]  DEPTH_C = DEPTH[IDX_W:0];
    localparam logic [GW-1:0]   LAST_G  = GW'(GROUPS - 1);

    // start/done handshake: start is taken only when idle and no done is showing;
    // done is a single-cycle pulse and found/found_idx hold until the next done.
    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [COORD_W-1:0] r_x [DEPTH];
    logic [COORD_W-1:0] r_y [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [CNT_W-1:0]   r_count;
    logic [GW-1:0]      r_grp;
    logic [COORD_W-1:0] r_key_x, r_key_y;
    logic               r_done, r_found;
    logic [IDX_W-1:0]   r_found_idx;
    logic               w_wr_ok, w_accept, w_finish, w_hit;
    logic [IDX_W-1:0]   w_lane_idx, w_hit_idx;
`ifdef OPEN_SEARCH_FCOST_EN
    logic [FCOST_W-1:0] r_f [DEPTH];
    logic [FCOST_W-1:0] r_found_fcost, w_hit_fcost;
`endif

    assign w_wr_ok = wr_en && ({1'b0, wr_idx} < DEPTH_C);

    // Lanes are visited high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_lane_idx = '0;
`ifdef OPEN_SEARCH_FCOST_EN
        w_hit_fcost = '0;
`endif
        for (int l = LANES - 1; l >= 0; l--) begin
            w_lane_idx = IDX_W'(r_grp * LANES) + IDX_W'(l);
            if (r_valid[w_lane_idx] && (r_x[w_lane_idx] == r_key_x) &&
                (r_y[w_lane_idx] == r_key_y)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_lane_idx;
`ifdef OPEN_SEARCH_FCOST_EN
                w_hit_fcost = r_f[w_lane_idx];
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_hit || (r_grp == LAST_G)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
            r_grp       <= '0;
            r_key_x     <= '0;
            r_key_y     <= '0;
`ifdef OPEN_SEARCH_FCOST_EN
            r_found_fcost <= '0;
`endif
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_key_x <= key_x;
                r_key_y <= key_y;
                r_grp   <= '0;
            end else if ((r_state == S_SCAN) && !w_finish) begin
                r_grp <= r_grp + GW'(1);
            end
            if (w_finish) begin
                r_found     <= w_hit;
                r_found_idx <= w_hit_idx;
`ifdef OPEN_SEARCH_FCOST_EN
                r_found_fcost <= w_hit_fcost;
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (clear_all) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (w_wr_ok) begin
            r_valid[wr_idx] <= wr_valid;
            if (wr_valid && !r_valid[wr_idx])      r_count <= r_count + CNT_W'(1);
            else if (!wr_valid && r_valid[wr_idx]) r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge Clk) begin
        if (w_wr_ok && !clear_all) begin
            r_x[wr_idx] <= wr_x;
            r_y[wr_idx] <= wr_y;
`ifdef OPEN_SEARCH_FCOST_EN
            r_f[wr_idx] <= wr_fcost;
`endif
        end
    end

    assign busy        = (r_state == S_SCAN);
    assign done        = r_done;
    assign found       = r_found;
    assign found_idx   = r_found_idx;
    assign count       = r_count;
    assign o_dbg_state = r_state;
`ifdef OPEN_SEARCH_FCOST_EN
    assign found_fcost = r_found_fcost;
`endif
endmodule

// File: tb/tb_open_list_search_par.sv
// Bench for open_list_search_par: vector table plus hand-written scan corner sequences.
// Exercises the f-cost path too when OPEN_SEARCH_FCOST_EN is defined.
module tb_open_list_search_par;
    localparam int COORD_W = 8;
    localparam int DEPTH   = 400;
    localparam int LANES   = 4;
    localparam int IDX_W   = 9;
    localparam int CNT_W   = 9;
    localparam int GROUPS  = DEPTH / LANES;
    localparam int SB_W    = 1 + IDX_W + 16;
    localparam int BOUND   = 200;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               start, wr_en, wr_valid, clear_all;
    logic [COORD_W-1:0] key_x, key_y, wr_x, wr_y;
    logic [IDX_W-1:0]   wr_idx;
    logic               busy, done, found, dbg_state;
    logic [IDX_W-1:0]   found_idx;
    logic [CNT_W-1:0]   count;
    logic [15:0]        wr_fcost;
`ifdef OPEN_SEARCH_FCOST_EN
    logic [15:0]        found_fcost;
`endif

    open_list_search_par #(.COORD_W(COORD_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .key_x(key_x), .key_y(key_y),
        .busy(busy), .done(done), .found(found), .found_idx(found_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_valid(wr_valid),
        .clear_all(clear_all),
`ifdef OPEN_SEARCH_FCOST_EN
        .wr_fcost(wr_fcost), .found_fcost(found_fcost),
`endif
        .count(count), .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [SB_W-1:0] exp_q[$];

    logic [7:0] m_x [DEPTH];
    logic [7:0] m_y [DEPTH];
    logic       m_v [DEPTH];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       ef;
        logic [8:0] eidx;
        int         elat;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
        return c;
    endfunction

    function automatic void model_find(input logic [7:0] x, input logic [7:0] y,
                                       output logic f, output logic [8:0] idx);
        f = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!f && m_v[i] && m_x[i] == x && m_y[i] == y) begin
                f = 1'b1;
                idx = 9'(i);
            end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    endfunction

    // driver: one-cycle write
    task automatic wr(input int idx, input logic [7:0] x, input logic [7:0] y,
                      input logic v, input logic [15:0] fc);
        @(negedge Clk);
        wr_en = 1'b1; wr_idx = 9'(idx); wr_x = x; wr_y = y; wr_valid = v; wr_fcost = fc;
        @(negedge Clk);
        wr_en = 1'b0;
        if (idx < DEPTH) begin
            m_x[idx] = x; m_y[idx] = y; m_v[idx] = v;
        end
    endtask

    // driver + scoreboard: push expectation, run search, pop on done
    task automatic search(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic ef, input logic [8:0] eidx, input int elat);
        logic [SB_W-1:0] e;
        int lat;
        exp_q.push_back({ef, eidx, 16'(elat)});
        @(negedge Clk);
        key_x = x; key_y = y; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        key_x = ~x; key_y = ~y;
        lat = 0;
        while (!done && lat < BOUND) begin
            @(negedge Clk);
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e[15:0]));
        check({tag, " found"}, 32'(found), 32'(e[SB_W-1]));
        check({tag, " idx"}, 32'(found_idx), 32'(e[SB_W-2:16]));
        @(negedge Clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " found held"}, 32'(found), 32'(e[SB_W-1]));
    endtask

    function automatic int exp_lat(input logic f, input logic [8:0] idx);
        return f ? (int'(idx) / LANES + 1) : GROUPS;
    endfunction

    initial begin
        logic       f;
        logic [8:0] idx;
        logic [7:0] rx, ry;
        int         ri, lat, extra;

        start = 0; wr_en = 0; wr_valid = 0; clear_all = 0;
        key_x = 0; key_y = 0; wr_x = 0; wr_y = 0; wr_idx = 0; wr_fcost = 0;
        model_clear();

        // reset block
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset found", 32'(found), 0);
        check("reset idx", 32'(found_idx), 0);
        check("reset count", 32'(count), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post-reset dbg_state", 32'(dbg_state), 0);

        // fill: idx i holds (i%256, i/256)
        for (int i = 0; i < DEPTH; i++) wr(i, 8'(i % 256), 8'(i / 256), 1'b1, 16'(i));
        check("fill count", 32'(count), 32'(model_count()));

        vecs[0] = '{8'd5,   8'd0,   1'b1, 9'd5,   2};
        vecs[1] = '{8'd0,   8'd0,   1'b1, 9'd0,   1};
        vecs[2] = '{8'd3,   8'd0,   1'b1, 9'd3,   1};
        vecs[3] = '{8'd4,   8'd0,   1'b1, 9'd4,   2};
        vecs[4] = '{8'd143, 8'd1,   1'b1, 9'd399, 100};
        vecs[5] = '{8'd200, 8'd200, 1'b0, 9'd0,   100};
        vecs[6] = '{8'd255, 8'd0,   1'b1, 9'd255, 64};
        vecs[7] = '{8'd0,   8'd1,   1'b1, 9'd256, 65};
        vecs[8] = '{8'd144, 8'd1,   1'b0, 9'd0,   100};
        vecs[9] = '{8'd5,   8'd1,   1'b1, 9'd261, 66};
        for (int v = 0; v < 10; v++)
            search($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].ef, vecs[v].eidx,
                   vecs[v].elat);

        for (int r = 0; r < 6; r++) begin
            ri = $urandom_range(0, DEPTH - 1);
            rx = 8'(ri % 256);
            ry = 8'(ri / 256);
            if (r % 3 == 2) begin
                rx = 8'($urandom_range(144, 255));
                ry = 8'd1;
            end
            model_find(rx, ry, f, idx);
            search($sformatf("rand%0d", r), rx, ry, f, idx, exp_lat(f, idx));
        end

        // duplicates, removal, out-of-range write
        wr(10, 8'd7, 8'd7, 1'b1, 16'h0);
        wr(3, 8'd7, 8'd7, 1'b1, 16'h0);
        check("dup count", 32'(count), 32'd400);
        search("dup lowest", 8'd7, 8'd7, 1'b1, 9'd3, 1);
        wr(3, 8'd7, 8'd7, 1'b0, 16'h0);
        check("remove count", 32'(count), 32'd399);
        search("after remove", 8'd7, 8'd7, 1'b1, 9'd10, 3);
        wr(450, 8'd1, 8'd1, 1'b1, 16'h0);
        check("oob write count", 32'(count), 32'd399);
        wr(3, 8'd9, 8'd9, 1'b0, 16'h0);
        check("re-remove count", 32'(count), 32'd399);
        wr(3, 8'd3, 8'd0, 1'b1, 16'h0);
        check("restore count", 32'(count), 32'(model_count()));

        // clear_all mid-scan, key at idx 300; start pulses while busy ignored
        exp_q.push_back({1'b0, 9'd0, 16'd100});
        @(negedge Clk);
        key_x = 8'd44; key_y = 8'd1; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        lat = 0;
        check("clr busy", 32'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            lat++;
            start = (k % 3 == 0);
            clear_all = (k == 10);
        end
        @(negedge Clk);
        lat++;
        start = 1'b0;
        clear_all = 1'b0;
        model_clear();
        check("clr count", 32'(count), 0);
        while (!done && lat < BOUND) begin
            @(negedge Clk);
            lat++;
        end
        begin
            logic [SB_W-1:0] e;
            e = exp_q.pop_front();
            check("clr latency", 32'(lat), 32'(e[15:0]));
            check("clr found", 32'(found), 32'(e[SB_W-1]));
            check("clr idx", 32'(found_idx), 32'(e[SB_W-2:16]));
        end
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        extra = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge Clk);
            if (done) extra++;
        end
        check("no extra done", 32'(extra), 0);
        check("idle after clr", 32'(busy), 0);

        // reset during scan
        wr(5, 8'd5, 8'd0, 1'b1, 16'h0);
        wr(399, 8'd143, 8'd1, 1'b1, 16'h0);
        check("refill count", 32'(count), 32'd2);
        @(negedge Clk);
        key_x = 8'd143; key_y = 8'd1; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (20) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst count", 32'(count), 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        model_clear();
        extra = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge Clk);
            if (done) extra++;
        end
        check("rst no done", 32'(extra), 0);
        search("old key miss", 8'd5, 8'd0, 1'b0, 9'd0, 100);

`ifdef OPEN_SEARCH_FCOST_EN
        wr(42, 8'd9, 8'd9, 1'b1, 16'h1234);
        search("fcost hit", 8'd9, 8'd9, 1'b1, 9'd42, 11);
        check("fcost value", 32'(found_fcost), 32'h1234);
        search("fcost miss", 8'd8, 8'd8, 1'b0, 9'd0, 100);
        check("fcost zero", 32'(found_fcost), 0);
`endif

        check("scoreboard empty", 32'(exp_q.size()), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
